// File: rtl/lcd_dma_fifo_p_if.sv
`default_nettype none
// ============================================================================
// Module      : lcd_dma_fifo_p_if
// Description : Bus bundle for the LCD DMA pixel FIFO. It carries the DMA write
//               strobe and data, the serializer read strobe and registered
//               read data, and the burst request/acknowledge handshake.
//               master : DMA/serializer side (drives push, data_in, pull,
//                        dma_ack; observes data_out, rd_valid, dma_req)
//               slave  : FIFO side (the mirror image)
// Revision    : 1.0 - initial release
// ============================================================================
interface lcd_dma_fifo_p_if #(
    parameter int DATA_W = 32
);
    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pull;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              dma_req;
    logic              dma_ack;

    modport master (
        output push, data_in, pull, dma_ack,
        input  data_out, rd_valid, dma_req
    );

    modport slave (
        input  push, data_in, pull, dma_ack,
        output data_out, rd_valid, dma_req
    );
endinterface
`default_nettype wire

// File: rtl/lcd_dma_fifo_p.sv
`default_nettype none
// ============================================================================
// Module      : lcd_dma_fifo_p
// Description : Parametrised DMA-side pixel FIFO for the LCD controller.
//               Register-array storage, registered read port with a one-cycle
//               valid strobe, burst-refill request FSM and a synchronous
//               per-frame flush.
// Ports       : clk, rst (async assert, active-low)
//               bus        lcd_dma_fifo_p_if.slave (push/data_in, pull/
//                          data_out/rd_valid, dma_req/dma_ack)
//               i_flush    frame-pulse flush (highest priority)
//               i_req_en   enables refill requests
//               i_err_clr  clears sticky error flags
//               o_full, o_empty, o_level, o_space   occupancy status
//               o_ovf, o_udf                        sticky error flags
// Options     : LCD_FIFO_ERR_EN - when defined, builds the sticky overflow /
//               underflow flags; otherwise they are tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_dma_fifo_p #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int BURST  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    lcd_dma_fifo_p_if.slave        bus,
    input  logic                   i_flush,
    input  logic                   i_req_en,
    input  logic                   i_err_clr,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level,
    output logic [$clog2(DEPTH):0] o_space,
    output logic                   o_ovf,
    output logic                   o_udf
);

    localparam int          AW        = $clog2(DEPTH);
    localparam logic [AW:0] c_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_BURST   = (AW+1)'(BURST);
    localparam logic [AW:0] c_LVL_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FILL = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [AW:0]       r_beat_cnt;
    logic [AW:0]       w_beat_nxt;
    logic              r_dma_req;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_level;
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    logic              w_full;
    logic              w_empty;
    logic [AW:0]       w_space;
    logic              w_pull_acc;
    logic              w_push_acc;

    assign w_full  = (r_level == c_DEPTH);
    assign w_empty = (r_level == '0);
    assign w_space = c_DEPTH - r_level;

    // A pull frees a slot in the same cycle, so a full FIFO still takes a
    // push when a pull is accepted alongside it. Flush masks both strobes.
    assign w_pull_acc = bus.pull && !w_empty && !i_flush;
    assign w_push_acc = bus.push && (!w_full || w_pull_acc) && !i_flush;

    assign o_full       = w_full;
    assign o_empty      = w_empty;
    assign o_level      = r_level;
    assign o_space      = w_space;
    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;
    assign bus.dma_req  = r_dma_req;

    // Storage is not reset and not flushed; only pointers define contents.
    always_ff @(posedge clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else if (i_flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pull_acc;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pull_acc) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_data_out <= r_mem[r_rd_ptr];
            end
            case ({w_push_acc, w_pull_acc})
                2'b10:   r_level <= r_level + c_LVL_ONE;
                2'b01:   r_level <= r_level - c_LVL_ONE;
                default: r_level <= r_level;
            endcase
        end
    end

    // Refill FSM: state register. dma_req is registered from the next state
    // so it is high exactly while the FSM sits in REQ.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_beat_cnt <= '0;
            r_dma_req  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_beat_cnt <= w_beat_nxt;
            r_dma_req  <= (w_state_nxt == S_REQ);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_beat_nxt  = r_beat_cnt;
        if (i_flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_en && (w_space >= c_BURST)) begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_REQ: begin
                    if (bus.dma_ack) begin
                        w_beat_nxt  = c_BURST;
                        w_state_nxt = S_FILL;
                    end else if (!i_req_en) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_FILL: begin
                    if (w_push_acc) begin
                        w_beat_nxt = r_beat_cnt - c_LVL_ONE;
                        if (r_beat_cnt == c_LVL_ONE) begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

`ifdef LCD_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;
    logic w_ovf_set;
    logic w_udf_set;

    assign w_ovf_set = bus.push && w_full && !w_pull_acc && !i_flush;
    assign w_udf_set = bus.pull && w_empty && !i_flush;

    // Set has priority over clear so a coincident event is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (i_err_clr) begin
                r_ovf <= 1'b0;
            end
            if (w_udf_set) begin
                r_udf <= 1'b1;
            end else if (i_err_clr) begin
                r_udf <= 1'b0;
            end
        end
    end

    assign o_ovf = r_ovf;
    assign o_udf = r_udf;
`else
    logic w_unused_err_clr;
    assign w_unused_err_clr = i_err_clr;
    assign o_ovf = 1'b0;
    assign o_udf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lcd_dma_fifo_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_dma_fifo_p
// Description : Self-checking bench for lcd_dma_fifo_p (DEPTH=32, BURST=8).
//               A queue model of the FIFO feeds a read scoreboard; a vector
//               table covers the basic accept rules and hand sequences cover
//               refill bursts, wrap, full/overflow, flush and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lcd_dma_fifo_p;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int BURST  = 8;
    localparam int AW     = $clog2(DEPTH);
`ifdef LCD_FIFO_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          req_en = 1'b0;
    logic          err_clr = 1'b0;
    logic          o_full, o_empty, o_ovf, o_udf;
    logic [AW:0]   o_level, o_space;

    lcd_dma_fifo_p_if #(.DATA_W(DATA_W)) bus ();

    lcd_dma_fifo_p #(.DATA_W(DATA_W), .DEPTH(DEPTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .i_flush   (flush),
        .i_req_en  (req_en),
        .i_err_clr (err_clr),
        .o_full    (o_full),
        .o_empty   (o_empty),
        .o_level   (o_level),
        .o_space   (o_space),
        .o_ovf     (o_ovf),
        .o_udf     (o_udf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] mq[$];     // model FIFO contents
    logic [DATA_W-1:0] exp_q[$];  // scoreboard of expected read data
    bit m_ovf = 1'b0;
    bit m_udf = 1'b0;

    typedef struct {
        bit                push;
        bit                pull;
        bit                clr;
        logic [DATA_W-1:0] data;
        int                exp_level;
        bit                exp_rdv;
        bit                exp_udf;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_status();
        chk("level", o_level, mq.size());
        chk("empty", o_empty, mq.size() == 0);
        chk("full",  o_full,  mq.size() == DEPTH);
        chk("space", o_space, DEPTH - mq.size());
        chk("ovf",   o_ovf,   ERR ? m_ovf : 1'b0);
        chk("udf",   o_udf,   ERR ? m_udf : 1'b0);
    endtask

    task automatic chk_rst();
        chk("rst_level",    o_level, 0);
        chk("rst_empty",    o_empty, 1);
        chk("rst_full",     o_full, 0);
        chk("rst_space",    o_space, DEPTH);
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_data_out", bus.data_out, 0);
        chk("rst_dma_req",  bus.dma_req, 0);
        chk("rst_ovf",      o_ovf, 0);
        chk("rst_udf",      o_udf, 0);
    endtask

    task automatic clr_model();
        mq.delete();
        exp_q.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.push    = 1'b0;
        bus.pull    = 1'b0;
        bus.data_in = '0;
        bus.dma_ack = 1'b0;
        err_clr     = 1'b0;
        flush       = 1'b0;
    endtask

    // One clock of stimulus. The model decides acceptance, queues expected
    // read data, and the post-edge sample is compared against it.
    task automatic cyc(input bit p, input logic [DATA_W-1:0] d, input bit q,
                       input bit ack = 1'b0, input bit clr = 1'b0);
        bit m_full, m_empty, qacc, pacc;
        m_full  = (mq.size() == DEPTH);
        m_empty = (mq.size() == 0);
        qacc    = q && !m_empty;
        pacc    = p && (!m_full || qacc);
        if (p && m_full && !qacc) m_ovf = 1'b1;
        else if (clr)             m_ovf = 1'b0;
        if (q && m_empty)         m_udf = 1'b1;
        else if (clr)             m_udf = 1'b0;
        bus.push    = p;
        bus.data_in = d;
        bus.pull    = q;
        bus.dma_ack = ack;
        err_clr     = clr;
        if (qacc) exp_q.push_back(mq.pop_front());
        if (pacc) mq.push_back(d);
        @(posedge clk);
        #1;
        idle_inputs();
        chk("rd_valid", bus.rd_valid, qacc);
        if (bus.rd_valid && exp_q.size() > 0) begin
            chk("data_out", bus.data_out, exp_q.pop_front());
        end
        chk_status();
    endtask

    task automatic do_reset();
        rst    = 1'b0;
        req_en = 1'b0;
        idle_inputs();
        clr_model();
        @(posedge clk);
        #1;
        chk_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             push pull clr data        lvl rdv udf
        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'hA1, 1, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 32'hB2, 1, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'hC3, 1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 32'h0,  1, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0,  1, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b1, 1'b0, 32'h0,  0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1, 1'b1, 32'h0,  0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 32'h0,  0, 1'b0, 1'b0};

        idle_inputs();

        // Reset, then a refill burst of 8 words
        do_reset();
        req_en = 1'b1;
        cyc(1'b0, '0, 1'b0);
        chk("t1_dma_req_rise", bus.dma_req, 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        chk("t1_dma_req_fall", bus.dma_req, 0);
        for (int i = 0; i < 7; i++) cyc(1'b1, 32'h10 + i, 1'b0);
        cyc(1'b0, '0, 1'b0);
        chk("t1_fill_hold", bus.dma_req, 0);
        cyc(1'b1, 32'h17, 1'b0);
        chk("t1_last_beat", bus.dma_req, 0);
        chk("t1_level8", o_level, 8);
        cyc(1'b0, '0, 1'b0);
        chk("t1_rereq", bus.dma_req, 1);
        req_en = 1'b0;
        cyc(1'b0, '0, 1'b0);
        chk("t1_req_drop", bus.dma_req, 0);
        for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1);

        // Fill completely, drain back-to-back, then prove pointer wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, DATA_W'(i), 1'b0);
        chk("t2_full", o_full, 1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);
        chk("t2_empty", o_empty, 1);
        cyc(1'b1, 32'hAA, 1'b0);
        cyc(1'b0, '0, 1'b1);

        // Full with push+pull, then push alone (overflow), clear, drain
        do_reset();
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 32'h100 + i, 1'b0);
        cyc(1'b1, 32'h200, 1'b1);
        chk("t3_level_pp", o_level, 32);
        cyc(1'b1, 32'h300, 1'b0);
        chk("t3_ovf", o_ovf, ERR);
        cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b1);

        // Table: basic accept rules, empty push+pull, sticky underflow
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(tbl[i].push, tbl[i].data, tbl[i].pull, 1'b0, tbl[i].clr);
            chk("tbl_level", o_level, tbl[i].exp_level);
            chk("tbl_rd_valid", bus.rd_valid, tbl[i].exp_rdv);
            chk("tbl_udf", o_udf, ERR & tbl[i].exp_udf);
        end

        // Flush during FILL with level 20 and 3 beats outstanding
        do_reset();
        for (int i = 0; i < 15; i++) cyc(1'b1, 32'h400 + i, 1'b0);
        req_en = 1'b1;
        cyc(1'b0, '0, 1'b0);
        chk("t5_req", bus.dma_req, 1);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h500 + i, 1'b0);
        chk("t5_level20", o_level, 20);
        flush       = 1'b1;
        bus.push    = 1'b1;
        bus.data_in = 32'hDEAD;
        bus.pull    = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        mq.delete();
        exp_q.delete();
        chk("t5_flush_level", o_level, 0);
        chk("t5_flush_empty", o_empty, 1);
        chk("t5_flush_rdv", bus.rd_valid, 0);
        chk("t5_flush_req", bus.dma_req, 0);
        cyc(1'b0, '0, 1'b0);
        chk("t5_rereq", bus.dma_req, 1);
        req_en = 1'b0;
        cyc(1'b1, 32'h55, 1'b0);
        cyc(1'b0, '0, 1'b1);

        // Asynchronous reset mid-FILL with level 12 and a read in flight
        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h600 + i, 1'b0);
        req_en = 1'b1;
        cyc(1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h700 + i, 1'b0);
        cyc(1'b1, 32'h704, 1'b1);
        chk("t6_level12", o_level, 12);
        #3;
        rst = 1'b0;
        #1;
        clr_model();
        chk_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, '0, 1'b0);
        chk("t6_idle_after_rst", bus.dma_req, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
